// File: rtl/ray_frame_scheduler.sv
// Per-frame ray column sequencer: snapshots the camera on frame start, issues columns
// 0..SCREEN_WIDTH-1 under valid/ready, then waits for frame_done. Optional macro: RAY_SCHED_TIMEOUT_EN.
module ray_frame_scheduler #(
    parameter int SCREEN_WIDTH   = 320,
    parameter int HCOUNT_W       = 9,
    parameter int CAM_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                pixel_clk_in,
    input  logic                rst_n_in,
    input  logic                frame_start_in,
    input  logic                cam_valid_in,
    input  logic [CAM_W-1:0]    posX_in,
    input  logic [CAM_W-1:0]    posY_in,
    input  logic [CAM_W-1:0]    dirX_in,
    input  logic [CAM_W-1:0]    dirY_in,
    input  logic [CAM_W-1:0]    planeX_in,
    input  logic [CAM_W-1:0]    planeY_in,
    input  logic                ray_ready_in,
    input  logic                frame_done_in,
    output logic                ray_valid_out,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [CAM_W-1:0]    posX_out,
    output logic [CAM_W-1:0]    posY_out,
    output logic [CAM_W-1:0]    dirX_out,
    output logic [CAM_W-1:0]    dirY_out,
    output logic [CAM_W-1:0]    planeX_out,
    output logic [CAM_W-1:0]    planeY_out,
    output logic                ray_last_out,
    output logic                busy_out,
    output logic [7:0]          overrun_count_out,
    output logic                timeout_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [HCOUNT_W-1:0] LAST_COL = HCOUNT_W'(SCREEN_WIDTH - 1);

    if ((2 ** HCOUNT_W) < SCREEN_WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ray_frame_scheduler: bad HCOUNT_W/SCREEN_WIDTH/TIMEOUT_CYCLES");
    end

    state_t              r_state, w_next;
    logic [HCOUNT_W-1:0] r_hcount;
    logic [CAM_W-1:0]    r_posX, r_posY, r_dirX, r_dirY, r_planeX, r_planeY;
    logic [7:0]          r_overrun;
    logic                w_xfer, w_last, w_accept, w_overrun, w_to_expire;

    assign w_last    = (r_state == ISSUE) && (r_hcount == LAST_COL);
    assign w_xfer    = (r_state == ISSUE) && ray_ready_in;
    assign w_overrun = frame_start_in && !w_accept;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start_in && cam_valid_in) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: begin
                if (w_xfer && w_last) w_next = DRAIN;
            end
            DRAIN: begin
                // A same-cycle done+start chains straight into the next frame.
                if (frame_done_in) begin
                    if (frame_start_in && cam_valid_in) begin
                        w_accept = 1'b1;
                        w_next   = ISSUE;
                    end else begin
                        w_next = IDLE;
                    end
                end else if (w_to_expire) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state   <= IDLE;
            r_hcount  <= '0;
            r_posX    <= '0;
            r_posY    <= '0;
            r_dirX    <= '0;
            r_dirY    <= '0;
            r_planeX  <= '0;
            r_planeY  <= '0;
            r_overrun <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_hcount <= '0;
                r_posX   <= posX_in;
                r_posY   <= posY_in;
                r_dirX   <= dirX_in;
                r_dirY   <= dirY_in;
                r_planeX <= planeX_in;
                r_planeY <= planeY_in;
            end else if (w_xfer && !w_last) begin
                r_hcount <= r_hcount + 1'b1;
            end
            if (w_overrun && r_overrun != 8'hFF) r_overrun <= r_overrun + 1'b1;
        end
    end

`ifdef RAY_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_to_expire = (r_state == DRAIN) && !frame_done_in
                         && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != DRAIN) r_to_cnt <= '0;
            else                  r_to_cnt <= r_to_cnt + 1'b1;
            if (w_to_expire) r_timeout <= 1'b1;
        end
    end

    assign timeout_out = r_timeout;
`else
    assign w_to_expire = 1'b0;
    assign timeout_out = 1'b0;
`endif

    assign ray_valid_out     = (r_state == ISSUE);
    assign ray_last_out      = w_last;
    assign busy_out          = (r_state != IDLE);
    assign hcount_out        = r_hcount;
    assign posX_out          = r_posX;
    assign posY_out          = r_posY;
    assign dirX_out          = r_dirX;
    assign dirY_out          = r_dirY;
    assign planeX_out        = r_planeX;
    assign planeY_out        = r_planeY;
    assign overrun_count_out = r_overrun;

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Directed bench for ray_frame_scheduler: vector table plus multi-cycle frame sequences.
module tb_ray_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fs, cv, rdy, fd;
    logic [15:0] posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in;
    logic        valid, last, busy, tmo;
    logic [8:0]  hc;
    logic [15:0] posX, posY, dirX, dirY, planeX, planeY;
    logic [7:0]  ovr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ray_frame_scheduler #(.SCREEN_WIDTH(320), .HCOUNT_W(9), .CAM_W(16), .TIMEOUT_CYCLES(50)) dut (
        .pixel_clk_in(clk), .rst_n_in(rst_n), .frame_start_in(fs), .cam_valid_in(cv),
        .posX_in(posX_in), .posY_in(posY_in), .dirX_in(dirX_in), .dirY_in(dirY_in),
        .planeX_in(planeX_in), .planeY_in(planeY_in), .ray_ready_in(rdy), .frame_done_in(fd),
        .ray_valid_out(valid), .hcount_out(hc), .posX_out(posX), .posY_out(posY),
        .dirX_out(dirX), .dirY_out(dirY), .planeX_out(planeX), .planeY_out(planeY),
        .ray_last_out(last), .busy_out(busy), .overrun_count_out(ovr), .timeout_out(tmo)
    );

    typedef struct {
        logic        fs, cv, fd, rdy;
        logic [15:0] px;
        logic        e_valid;
        logic [8:0]  e_hc;
        logic        e_busy;
        logic [15:0] e_px;
        logic [7:0]  e_ovr;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int bad, lastbad, c, exp_hc, n, drop;

        // fs cv fd rdy posX_in | valid hc busy posX_out ovr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 9'd0, 1'b0, 16'h0000, 8'd1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 9'd0, 1'b0, 16'h0000, 8'd1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0380, 1'b1, 9'd0, 1'b1, 16'h0380, 8'd1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b1, 9'd0, 1'b1, 16'h0380, 8'd1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b1, 9'd1, 1'b1, 16'h0380, 8'd1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h3333, 1'b1, 9'd2, 1'b1, 16'h0380, 8'd2};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 9'd2, 1'b1, 16'h0380, 8'd2};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 9'd3, 1'b1, 16'h0380, 8'd2};

        rst_n = 1'b0; fs = 0; cv = 0; rdy = 0; fd = 0;
        posX_in = 0; posY_in = 0; dirX_in = 0; dirY_in = 0; planeX_in = 0; planeY_in = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", valid, 0);
        check("rst_hcount", hc, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", ovr, 0);
        check("rst_last", last, 0);
        check("rst_timeout", tmo, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            fs = vecs[i].fs; cv = vecs[i].cv; fd = vecs[i].fd; rdy = vecs[i].rdy;
            posX_in = vecs[i].px;
            tick();
            check($sformatf("vec%0d_valid", i), valid, vecs[i].e_valid);
            check($sformatf("vec%0d_hcount", i), hc, vecs[i].e_hc);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d_posX", i), posX, vecs[i].e_px);
            check($sformatf("vec%0d_ovr", i), ovr, vecs[i].e_ovr);
        end
        fs = 0; cv = 0; fd = 0; rdy = 0;

        // Full frame with ready held high; camera inputs wiggle mid-frame.
        do_reset();
        posX_in = 16'h0380; posY_in = 16'h0401; dirX_in = 16'hFF00;
        dirY_in = 16'h0012; planeX_in = 16'h00A8; planeY_in = 16'hBEEF;
        fs = 1; cv = 1; rdy = 1;
        tick();
        fs = 0; cv = 0;
        bad = 0; lastbad = 0;
        for (int i = 0; i < 320; i++) begin
            if (!valid || hc != 9'(i) || posX != 16'h0380) bad++;
            if (last != (i == 319)) lastbad++;
            if (i == 150) begin posX_in = 16'h7777; planeY_in = 16'h1234; end
            tick();
        end
        check("f1_beats", bad, 0);
        check("f1_last", lastbad, 0);
        check("f1_drain_valid", valid, 0);
        check("f1_drain_busy", busy, 1);
        check("f1_posY", posY, 16'h0401);
        check("f1_dirX", dirX, 16'hFF00);
        check("f1_dirY", dirY, 16'h0012);
        check("f1_planeX", planeX, 16'h00A8);
        check("f1_planeY", planeY, 16'hBEEF);
        repeat (10) tick();
        check("f1_drain_hold", {valid, busy}, 2'b01);

        // Ready toggling: low on even cycles, high on odd.
        fd = 1; tick(); fd = 0;
        check("f2_idle", busy, 0);
        posX_in = 16'h0200; fs = 1; cv = 1;
        tick();
        fs = 0; cv = 0;
        c = 0; exp_hc = 0; bad = 0;
        while (valid && c < 1000) begin
            if (hc != 9'(exp_hc) || posX != 16'h0200 || last != (exp_hc == 319)) bad++;
            rdy = c[0];
            tick();
            if (c[0]) exp_hc++;
            c++;
        end
        check("f2_beats", bad, 0);
        check("f2_cycles", c, 640);
        check("f2_transfers", exp_hc, 320);

        // Overruns at hcount 100 and in DRAIN; issue sequence unaffected.
        do_reset();
        posX_in = 16'h0100; fs = 1; cv = 1; rdy = 1;
        tick();
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            if (!valid || hc != 9'(i)) bad++;
            fs = (i == 100); cv = (i == 100);
            if (i == 100) posX_in = 16'h5555;
            tick();
        end
        fs = 0; cv = 0;
        check("f3_beats", bad, 0);
        check("f3_posX", posX, 16'h0100);
        fs = 1; cv = 1; tick(); fs = 0; cv = 0;
        check("f3_ovr", ovr, 2);
        check("f3_drain", {valid, busy}, 2'b01);

        // Done and start in the same DRAIN cycle chain into a new frame.
        fd = 1; fs = 1; cv = 1; posX_in = 16'h0ABC;
        tick();
        fd = 0; fs = 0; cv = 0;
        check("f4_valid", valid, 1);
        check("f4_hcount", hc, 0);
        check("f4_posX", posX, 16'h0ABC);
        check("f4_ovr", ovr, 2);

        // Asynchronous reset at hcount 57.
        n = 0;
        while (hc != 9'd57 && n < 100) begin tick(); n++; end
        check("f5_reach57", hc, 57);
        #2 rst_n = 1'b0;
        #1;
        check("f5_rst_all", {valid, hc, posX, busy, ovr, last}, 0);
        #2 rst_n = 1'b1;
        bad = 0;
        repeat (5) begin tick(); if (valid || busy) bad++; end
        check("f5_quiet", bad, 0);
        posX_in = 16'h0042; fs = 1; cv = 1;
        tick();
        fs = 0; cv = 0;
        check("f5_restart", {valid, hc, posX}, {1'b1, 9'd0, 16'h0042});

        // Drain without frame_done.
        n = 0;
        while (valid && n < 400) begin tick(); n++; end
        check("f6_in_drain", busy, 1);
        drop = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (!busy && drop == 0) drop = k;
        end
`ifdef RAY_SCHED_TIMEOUT_EN
        check("f6_timeout_at", drop, 50);
        check("f6_timeout_flag", tmo, 1);
        repeat (5) tick();
        check("f6_timeout_sticky", tmo, 1);
`else
        check("f6_drain_persists", drop, 0);
        check("f6_timeout_flag", tmo, 0);
`endif

        // Overrun counter saturates.
        do_reset();
        cv = 0;
        repeat (260) begin fs = 1; tick(); end
        fs = 0;
        check("f7_ovr_sat", ovr, 255);
        check("f7_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ray_frame_scheduler.md
Name: ray_frame_scheduler

Overview:
- Sequences per-frame ray generation. Replaces the free-running column counter that feeds ray_calculations.
- On each frame start, takes a snapshot of the camera state from controller. Then issues screen columns 0..SCREEN_WIDTH-1 exactly once, under a valid/ready handshake with the DDA-in FIFO path.
- Waits for the transformation stage's last-pixel indication before it accepts the next frame. Counts dropped frame starts.

Parameters:
- SCREEN_WIDTH, 320, number of columns issued per frame.
- HCOUNT_W, 9, width of hcount_out; must satisfy 2^HCOUNT_W >= SCREEN_WIDTH.
- CAM_W, 16, width of each camera field.
- TIMEOUT_CYCLES, 1000000, drain watchdog limit. Used only with RAY_SCHED_TIMEOUT_EN.

Ports:
- pixel_clk_in  in  1  pixel clock; single clock domain.
- rst_n_in  in  1  asynchronous, active-low reset.
- frame_start_in  in  1  one-cycle pulse requesting a new frame (video new-frame strobe).
- cam_valid_in  in  1  camera inputs are valid this cycle.
- posX_in, posY_in, dirX_in, dirY_in, planeX_in, planeY_in  in  CAM_W each  camera state from controller.
- ray_ready_in  in  1  downstream (ray_calculations / DDA-in FIFO) can accept a column.
- frame_done_in  in  1  pulse from transformation: last pixel of the frame written.
- ray_valid_out  out  1  hcount_out and the camera snapshot are valid.
- hcount_out  out  HCOUNT_W  column index being issued.
- posX_out, posY_out, dirX_out, dirY_out, planeX_out, planeY_out  out  CAM_W each  frame-stable camera snapshot.
- ray_last_out  out  1  high with the column SCREEN_WIDTH-1.
- busy_out  out  1  high in any state other than IDLE.
- overrun_count_out  out  8  saturating count of ignored frame starts.
- timeout_out  out  1  sticky drain-watchdog flag.

Behaviour:
- Reset (rst_n_in low, asynchronous) forces state IDLE and drives every output to 0, including the snapshot registers, hcount, the counter and the flag.
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - frame_start_in && cam_valid_in: latch all six camera fields, set hcount=0, go to ISSUE. ray_valid_out rises the next cycle.
  - frame_start_in && !cam_valid_in: stay in IDLE and increment overrun_count_out.
- ISSUE:
  - ray_valid_out=1.
  - A transfer occurs on a cycle where ray_valid_out && ray_ready_in.
  - On transfer with hcount < SCREEN_WIDTH-1: hcount increments by 1 the next cycle.
  - On transfer with hcount == SCREEN_WIDTH-1: ray_last_out is high on that beat; go to DRAIN and drop ray_valid_out the next cycle.
  - While not transferring, hcount_out, the snapshot and ray_last_out hold stable (no retraction, no change).
  - Throughput: one column per cycle when ray_ready_in stays high, so a full frame issues in SCREEN_WIDTH cycles.
- DRAIN:
  - ray_valid_out=0. Wait for frame_done_in, then go to IDLE.
  - frame_done_in && frame_start_in && cam_valid_in in the same cycle: go straight to ISSUE with a new snapshot and hcount=0.
- frame_start_in arriving in ISSUE, or in DRAIN without a same-cycle frame_done_in, is ignored: overrun_count_out increments, saturating at 255.
- frame_done_in arriving in IDLE or ISSUE is ignored.
- Camera inputs change freely; outputs change only at a snapshot.
- hcount never exceeds SCREEN_WIDTH-1. The comparison is unsigned, at HCOUNT_W width.
- Reset asserted mid-frame abandons the frame immediately. After release the block waits in IDLE for the next frame_start_in.

Optional Feature:
- Macro RAY_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs while in DRAIN and clears on entering DRAIN.
  - When it reaches TIMEOUT_CYCLES with no frame_done_in, force IDLE and set timeout_out=1.
  - timeout_out is sticky and clears only on reset.
- Undefined: DRAIN waits indefinitely, timeout_out is tied to 0, and no counter is synthesized.

Test Plan:
- Reset, then frame_start_in with cam_valid_in, posX_in=0x0380, ray_ready_in held 1 -> ray_valid_out for 320 consecutive cycles, hcount_out 0..319, posX_out=0x0380 throughout, ray_last_out only at hcount 319, then busy_out stays 1 in DRAIN.
- ray_ready_in toggled 1/0 each cycle -> each hcount is seen exactly once per transfer, outputs hold during the low cycles, and the frame completes after 640 cycles.
- frame_start_in at hcount 100 and again during DRAIN -> no restart, overrun_count_out=2, issue sequence unaffected.
- frame_done_in and frame_start_in in the same DRAIN cycle -> next cycle ray_valid_out=1, hcount_out=0, new snapshot loaded.
- rst_n_in pulsed low at hcount 57 -> all outputs 0 asynchronously; after release, nothing issues until the next frame_start_in, which starts at hcount 0.
- With RAY_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=50, no frame_done_in -> 50 cycles after entering DRAIN, busy_out=0 and timeout_out=1 (sticky); without the macro, DRAIN persists and timeout_out=0.
